// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: per-stage capture/bubble control for IF/ID, ID/EX, EX/MEM and PC.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int MC_MAX_CYCLES = 64,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_is_load,
    input  logic             ex_branch_taken,
    input  logic             ex_mc_start,
    input  logic             mc_done,
    input  logic             mem_stall,
    output logic             pc_en,
    output logic             if_id_valid,
    output logic             if_id_flush,
    output logic             id_ex_valid,
    output logic             id_ex_flush,
    output logic             ex_mem_valid,
    output logic             ex_mem_flush,
    output logic             mc_busy,
    output logic             mc_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int TW = $clog2(MC_MAX_CYCLES + 1);

    typedef enum logic {
        RUN,
        MC_WAIT
    } state_t;

    state_t        state, state_next;
    logic [TW-1:0] mc_cnt, mc_cnt_next;
    logic          timeout_q, timeout_set;
    logic          load_use;

    assign load_use = ex_is_load && (ex_rd_addr != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                       (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));

    assign mc_busy    = !reset && (state == MC_WAIT);
    assign mc_timeout = !reset && timeout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            mc_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state  <= state_next;
            mc_cnt <= mc_cnt_next;
            if (timeout_set)
                timeout_q <= 1'b1;
        end
    end

    always_comb begin
        state_next   = state;
        mc_cnt_next  = mc_cnt;
        timeout_set  = 1'b0;
        pc_en        = 1'b0;
        if_id_valid  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_valid  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_valid = 1'b0;
        ex_mem_flush = 1'b0;
        if (reset) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    // A memory freeze leaves every output low so all stages hold.
                    if (mem_stall) begin
                    end else if (ex_mc_start) begin
                        state_next   = MC_WAIT;
                        mc_cnt_next  = TW'(1);
                        ex_mem_flush = 1'b1;
                    end else if (ex_branch_taken) begin
                        pc_en        = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        ex_mem_valid = 1'b1;
                    end else if (load_use) begin
                        id_ex_flush  = 1'b1;
                        ex_mem_valid = 1'b1;
                    end else begin
                        pc_en        = 1'b1;
                        if_id_valid  = 1'b1;
                        id_ex_valid  = 1'b1;
                        ex_mem_valid = 1'b1;
                    end
                end
                MC_WAIT: begin
                    if (mem_stall) begin
                    end else if (mc_done) begin
                        pc_en        = 1'b1;
                        if_id_valid  = 1'b1;
                        id_ex_valid  = 1'b1;
                        ex_mem_valid = 1'b1;
                        state_next   = RUN;
                        mc_cnt_next  = '0;
                    end else if (mc_cnt == TW'(MC_MAX_CYCLES)) begin
                        // Abort: drop the stuck result and let the pipe advance.
                        timeout_set  = 1'b1;
                        state_next   = RUN;
                        mc_cnt_next  = '0;
                        pc_en        = 1'b1;
                        if_id_valid  = 1'b1;
                        id_ex_valid  = 1'b1;
                        ex_mem_flush = 1'b1;
                    end else begin
                        ex_mem_flush = 1'b1;
                        mc_cnt_next  = mc_cnt + TW'(1);
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en)
                stall_q <= stall_q + CNT_W'(1);
            if (if_id_flush)
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_q;
    assign flush_events = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: stimulus pushes expected outputs, a negedge monitor checks them.
// Counter expectations follow PIPE_PERF_CNT_EN the same way the design does.
module tb_pipe_hazard_ctrl;

    localparam int MC_MAX = 8;
    localparam int CNT_W  = 32;

    // Expected control words, excluding the mc_timeout bit:
    // {pc_en, if_id_valid, if_id_flush, id_ex_valid, id_ex_flush, ex_mem_valid, ex_mem_flush, mc_busy}
    localparam logic [7:0] E_RST  = 8'b0010_1010;
    localparam logic [7:0] E_NORM = 8'b1101_0100;
    localparam logic [7:0] E_LU   = 8'b0000_1100;
    localparam logic [7:0] E_BR   = 8'b1010_1100;
    localparam logic [7:0] E_FRZ  = 8'b0000_0000;
    localparam logic [7:0] E_FRZW = 8'b0000_0001;
    localparam logic [7:0] E_MCS  = 8'b0000_0010;
    localparam logic [7:0] E_MCW  = 8'b0000_0011;
    localparam logic [7:0] E_MCD  = 8'b1101_0101;
    localparam logic [7:0] E_MCT  = 8'b1101_0011;

    logic             clk;
    logic             reset;
    logic [4:0]       id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic             id_uses_rs1, id_uses_rs2, ex_is_load, ex_branch_taken;
    logic             ex_mc_start, mc_done, mem_stall;
    logic             pc_en, if_id_valid, if_id_flush, id_ex_valid, id_ex_flush;
    logic             ex_mem_valid, ex_mem_flush, mc_busy, mc_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    typedef struct {
        string            name;
        logic [8:0]       ctrl;
        logic             cnt_chk;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    logic             exp_tmo = 1'b0;
    logic             cnt_known = 1'b0;
    logic [CNT_W-1:0] m_stall = '0;
    logic [CNT_W-1:0] m_flush = '0;

    pipe_hazard_ctrl #(.MC_MAX_CYCLES(MC_MAX), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_rs1_addr    (id_rs1_addr),
        .id_rs2_addr    (id_rs2_addr),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .ex_rd_addr     (ex_rd_addr),
        .ex_is_load     (ex_is_load),
        .ex_branch_taken(ex_branch_taken),
        .ex_mc_start    (ex_mc_start),
        .mc_done        (mc_done),
        .mem_stall      (mem_stall),
        .pc_en          (pc_en),
        .if_id_valid    (if_id_valid),
        .if_id_flush    (if_id_flush),
        .id_ex_valid    (id_ex_valid),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_valid   (ex_mem_valid),
        .ex_mem_flush   (ex_mem_flush),
        .mc_busy        (mc_busy),
        .mc_timeout     (mc_timeout),
        .stall_cycles   (stall_cycles),
        .flush_events   (flush_events)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs just after the rising edge and queue what that cycle must show.
    task automatic applyStimulus(input string nm, input logic rst, input logic mst,
                                 input logic start, input logic done, input logic br,
                                 input logic ld, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic u1, input logic u2,
                                 input logic [7:0] exp8);
        exp_t e;
        @(posedge clk);
        #1;
        reset           = rst;
        mem_stall       = mst;
        ex_mc_start     = start;
        mc_done         = done;
        ex_branch_taken = br;
        ex_is_load      = ld;
        ex_rd_addr      = rd;
        id_rs1_addr     = rs1;
        id_rs2_addr     = rs2;
        id_uses_rs1     = u1;
        id_uses_rs2     = u2;
        e.name = nm;
        e.ctrl = {exp8, (rst ? 1'b0 : exp_tmo)};
`ifdef PIPE_PERF_CNT_EN
        e.cnt_chk = cnt_known;
        e.stall   = m_stall;
        e.flush   = m_flush;
        if (rst) begin
            m_stall   = '0;
            m_flush   = '0;
            cnt_known = 1'b1;
        end else begin
            if (!exp8[7]) m_stall = m_stall + 1'b1;
            if (exp8[5])  m_flush = m_flush + 1'b1;
        end
`else
        e.cnt_chk = 1'b1;
        e.stall   = '0;
        e.flush   = '0;
`endif
        sb.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [8:0] act;
        act = {pc_en, if_id_valid, if_id_flush, id_ex_valid, id_ex_flush,
               ex_mem_valid, ex_mem_flush, mc_busy, mc_timeout};
        checks++;
        if (act !== e.ctrl) begin
            errors++;
            $display("[TB] FAIL %s ctrl got %b want %b", e.name, act, e.ctrl);
        end
        if (e.cnt_chk) begin
            checks++;
            if (stall_cycles !== e.stall || flush_events !== e.flush) begin
                errors++;
                $display("[TB] FAIL %s counters got stall=%0d flush=%0d want stall=%0d flush=%0d",
                         e.name, stall_cycles, flush_events, e.stall, e.flush);
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1; mem_stall = 1'b0; ex_mc_start = 1'b0; mc_done = 1'b0;
        ex_branch_taken = 1'b0; ex_is_load = 1'b0; ex_rd_addr = '0;
        id_rs1_addr = '0; id_rs2_addr = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;

        applyStimulus("reset0", 1,0,0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, E_RST);
        applyStimulus("reset1", 1,0,0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, E_RST);
        applyStimulus("norm_nomatch", 0,0,0,0,0,1, 5'd3, 5'd1, 5'd2, 1,1, E_NORM);

        applyStimulus("loaduse_rs2", 0,0,0,0,0,1, 5'd5, 5'd1, 5'd5, 1,1, E_LU);
        applyStimulus("after_bubble", 0,0,0,0,0,0, 5'd0, 5'd1, 5'd5, 1,1, E_NORM);
        applyStimulus("load_rd0", 0,0,0,0,0,1, 5'd0, 5'd0, 5'd0, 1,1, E_NORM);
        applyStimulus("rs2_unused", 0,0,0,0,0,1, 5'd5, 5'd1, 5'd5, 1,0, E_NORM);
        applyStimulus("loaduse_rs1", 0,0,0,0,0,1, 5'd7, 5'd7, 5'd2, 1,0, E_LU);
        applyStimulus("noload_match", 0,0,0,0,0,0, 5'd7, 5'd7, 5'd7, 1,1, E_NORM);
        applyStimulus("branch_over_lu", 0,0,0,0,1,1, 5'd5, 5'd5, 5'd5, 1,1, E_BR);
        applyStimulus("done_in_run", 0,0,0,1,0,0, 5'd0, 5'd0, 5'd0, 0,0, E_NORM);

        applyStimulus("mc_start_br", 0,0,1,0,1,0, 5'd0, 5'd0, 5'd0, 0,0, E_MCS);
        for (int i = 0; i < 4; i++)
            applyStimulus("mc_wait", 0,0,1,0,1,1, 5'd5, 5'd5, 5'd5, 1,1, E_MCW);
        applyStimulus("mc_done", 0,0,0,1,0,0, 5'd0, 5'd0, 5'd0, 0,0, E_MCD);
        applyStimulus("after_done", 0,0,0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, E_NORM);

        // Freeze inside MC_WAIT must hold the counter, so the abort lands 3 cycles later.
        applyStimulus("mc_start2", 0,0,1,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, E_MCS);
        applyStimulus("mc_wait2a", 0,0,0,0,1,0, 5'd0, 5'd0, 5'd0, 0,0, E_MCW);
        for (int i = 0; i < 3; i++)
            applyStimulus("mc_freeze", 0,1,0,0,1,0, 5'd0, 5'd0, 5'd0, 0,0, E_FRZW);
        for (int i = 0; i < MC_MAX - 2; i++)
            applyStimulus("mc_wait2b", 0,0,0,0,1,0, 5'd0, 5'd0, 5'd0, 0,0, E_MCW);
        applyStimulus("mc_timeout_exit", 0,0,0,0,1,0, 5'd0, 5'd0, 5'd0, 0,0, E_MCT);
        exp_tmo = 1'b1;
        applyStimulus("tmo_sticky", 0,0,0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, E_NORM);

        applyStimulus("run_freeze_br", 0,1,0,0,1,0, 5'd0, 5'd0, 5'd0, 0,0, E_FRZ);
        applyStimulus("branch_after_frz", 0,0,0,0,1,0, 5'd0, 5'd0, 5'd0, 0,0, E_BR);
        applyStimulus("norm_tmo", 0,0,0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, E_NORM);

        exp_tmo = 1'b0;
        applyStimulus("reset2", 1,0,0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, E_RST);
        applyStimulus("tmo_cleared", 0,0,0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, E_NORM);
        applyStimulus("final_lu", 0,0,0,0,0,1, 5'd9, 5'd9, 5'd0, 1,0, E_LU);

        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain %0d entries left, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
